fetch_queue_bp: RTL and testbench
=================================

Name: fetch_queue_bp

Overview:
Parametrised next-generation front end that sits between memctrl and the decoder. It generates the fetch PC, predicts branch direction with a configurable predictor (static or bimodal 2-bit BHT), and buffers fetched instructions with their PC and prediction in an IQ_DEPTH-entry FIFO. The decoder then drains the FIFO independently. Incoming instructions are already expanded to 32 bits; is_c gives the original length.

Parameters:
IQ_DEPTH, 8, FIFO entries; power of two, minimum 2
BHT_ENTRIES, 16, number of 2-bit counters; power of two
PRED_MODE, 2, 0 = static not-taken, 1 = static taken, 2 = bimodal BHT
RESET_PC, 32'h0, fetch PC after reset

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous active-high reset
rdy_in  in  1  global enable; all state holds when low
clear  in  1  flush from ROB (mispredict)
melt  in  1  jalr target resolved; unfreeze
corr_jump_addr  in  32  redirect target for clear/melt
if_enable  out  1  fetch request to memctrl
if_addr  out  32  fetch address (current PC register)
inst_ready  in  1  fetched instruction valid this cycle
is_c  in  1  fetched instruction was compressed
inst_val  in  32  expanded instruction
out_valid  out  1  FIFO head valid
out_ready  in  1  decoder accepts head
out_inst  out  32  head instruction
out_pc  out  32  head PC
out_is_c  out  1  head compressed flag
out_pred_taken  out  1  head branch/jal predicted taken
out_next_pc  out  32  head predicted next PC
bp_update  in  1  predictor training strobe from ROB
bp_pc  in  32  PC of the resolved branch
bp_taken  in  1  actual branch outcome

Behaviour:
- Reset (async): pc=RESET_PC, FIFO empty, frozen=0, all BHT counters=2'b10 (weakly taken). Outputs: out_valid=0, out_* = 0, if_enable=0 while rst_in is high.
- rdy_in=0: no state change; bp_update is ignored.
- if_enable = !rst_in && !frozen && !clear && count<IQ_DEPTH; if_addr = pc.
- Pop: fires when rdy_in && !clear && out_valid && out_ready. Head is show-ahead and combinational from storage.
- Push: fires when rdy_in && !clear && !frozen && inst_ready && (count<IQ_DEPTH || pop).
  - A push with a pop on a full FIFO is legal; count is unchanged.
  - When inst_ready arrives but the push cannot fire, the instruction is dropped, pc is unchanged, and memctrl refetches.
- Next-PC on push, where len = is_c ? 2 : 4:
  - jal (1101111): pc+imm_j, pred_taken=1.
  - branch (1100011): pred_taken taken from PRED_MODE; in mode 2, pred_taken = BHT[pc[log2(BHT_ENTRIES):1]][1]. Next PC is pc+imm_b if taken, else pc+len.
  - jalr (1100111): pushed with next_pc=pc+len and pred_taken=0. Sets frozen=1; pc holds.
  - All other opcodes: pc+len, pred_taken=0.
  - The entry stores next_pc. All adds are 32-bit with wrap-around.
- clear (with rdy_in): FIFO emptied (head=tail=count=0), pc=corr_jump_addr, frozen=0. Push and pop are suppressed that cycle. clear has priority over melt.
- melt (with rdy_in, no clear): frozen=0, pc=corr_jump_addr. A same-cycle pop still proceeds.
- BHT update (rdy_in && bp_update): saturating counter at bp_pc[log2(BHT_ENTRIES):1]; increment if bp_taken, else decrement; saturates at 0 and 3. The update is applied even during clear.
- A same-cycle lookup and update at the same index sees the old value (no bypass).
- In PRED_MODE 0/1 the BHT is not instantiated and bp_update is ignored.
- FIFO pointers are log2(IQ_DEPTH) bits and wrap modulo IQ_DEPTH. count is log2(IQ_DEPTH)+1 bits.

Test Plan:
- Reset, RESET_PC=0; feed 8 non-branch 4-byte insts with out_ready=0 -> count=8, if_enable=0, pc=0x20. A 9th inst_ready is dropped and pc stays 0x20. Then a push and pop in the same cycle keep count=8.
- Branch at 0x40, imm_b=-16, mode 2, reset state -> pred_taken=1, next pc=0x30. Then two bp_update(0x40, taken=0) -> counter=0. Refetch 0x40 -> pred_taken=0, next pc=0x44.
- Compressed add at 0x100 (is_c=1) -> next pc=0x102, out_is_c=1, out_next_pc=0x102.
- jalr at 0x200 -> pushed, if_enable=0 for 5 cycles with pc=0x200. melt with corr_jump_addr=0x800 -> if_addr=0x800, if_enable=1.
- FIFO holding 5 entries; clear with corr_jump_addr=0x1000 while inst_ready=1 and out_ready=1 -> next cycle out_valid=0, pc=0x1000, the fetched inst is dropped, and no pop occurs.
- Assert rst_in mid-stream with FIFO at 3 entries and frozen=1 -> immediately out_valid=0 and if_enable=0. After release: pc=RESET_PC and BHT counters=2'b10.

Source files
------------

// File: rtl/fetch_queue_bp_if.sv
// Bus bundle for the fetch queue: memctrl fetch side, decoder drain side and
// the ROB predictor-training strobe.
interface fetch_queue_bp_if;
  // Handshakes: a fetch is accepted when inst_ready is high and the queue can
  // push (otherwise it is dropped and refetched from the unchanged if_addr);
  // a head entry transfers when out_valid && out_ready are both high on a
  // clock edge; bp_update is a single-cycle strobe sampled on the clock edge.
  logic        if_enable;
  logic [31:0] if_addr;
  logic        inst_ready;
  logic        is_c;
  logic [31:0] inst_val;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_is_c;
  logic        out_pred_taken;
  logic [31:0] out_next_pc;

  logic        bp_update;
  logic [31:0] bp_pc;
  logic        bp_taken;

  modport master (
    output if_enable, if_addr,
    output out_valid, out_inst, out_pc, out_is_c, out_pred_taken, out_next_pc,
    input  inst_ready, is_c, inst_val,
    input  out_ready,
    input  bp_update, bp_pc, bp_taken
  );

  modport slave (
    input  if_enable, if_addr,
    input  out_valid, out_inst, out_pc, out_is_c, out_pred_taken, out_next_pc,
    output inst_ready, is_c, inst_val,
    output out_ready,
    output bp_update, bp_pc, bp_taken
  );
endinterface

// File: rtl/fetch_queue_bp.sv
// Front end: fetch PC generation, static/bimodal branch prediction and an
// instruction queue the decoder drains independently.
module fetch_queue_bp #(
  parameter int          IQ_DEPTH    = 8,
  parameter int          BHT_ENTRIES = 16,
  parameter int          PRED_MODE   = 2,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      clear,
  input  logic                      melt,
  input  logic [31:0]               corr_jump_addr,
  fetch_queue_bp_if.master          bus,
  output logic [$clog2(IQ_DEPTH):0] dbg_count,
  output logic                      dbg_frozen
);

  localparam int PTR_W     = $clog2(IQ_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [31:0]      pc_q, pc_d;
  logic             frozen_q, frozen_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] mem_inst_q    [IQ_DEPTH];
  logic [31:0] mem_pc_q      [IQ_DEPTH];
  logic        mem_is_c_q    [IQ_DEPTH];
  logic        mem_pred_q    [IQ_DEPTH];
  logic [31:0] mem_next_pc_q [IQ_DEPTH];

  logic        full;
  logic        head_valid;
  logic        pop;
  logic        push;
  logic [6:0]  opcode;
  logic [31:0] imm_j;
  logic [31:0] imm_b;
  logic [31:0] len;
  logic        bht_pred;
  logic        pred_taken;
  logic        is_jalr;
  logic [31:0] next_pc;

  assign full       = (count_q == CNT_W'(IQ_DEPTH));
  assign head_valid = (count_q != '0);
  assign pop        = rdy_in && !clear && head_valid && bus.out_ready;
  // A full queue still accepts when the head leaves in the same cycle.
  assign push       = rdy_in && !clear && !frozen_q && bus.inst_ready && (!full || pop);

  // ---------------------------------------------------------------- predecode
  assign opcode = bus.inst_val[6:0];
  assign imm_j  = {{12{bus.inst_val[31]}}, bus.inst_val[19:12], bus.inst_val[20],
                   bus.inst_val[30:21], 1'b0};
  assign imm_b  = {{20{bus.inst_val[31]}}, bus.inst_val[7], bus.inst_val[30:25],
                   bus.inst_val[11:8], 1'b0};
  assign len    = bus.is_c ? 32'd2 : 32'd4;
  assign is_jalr = (opcode == OP_JALR);

  always_comb begin
    pred_taken = 1'b0;
    next_pc    = pc_q + len;
    case (opcode)
      OP_JAL: begin
        pred_taken = 1'b1;
        next_pc    = pc_q + imm_j;
      end
      OP_BRANCH: begin
        pred_taken = bht_pred;
        next_pc    = bht_pred ? (pc_q + imm_b) : (pc_q + len);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- predictor
  generate
    if (PRED_MODE == 2) begin : g_bht
      logic [1:0]           bht_q [BHT_ENTRIES];
      logic [1:0]           bht_d [BHT_ENTRIES];
      logic [BHT_IDX_W-1:0] look_idx;
      logic [BHT_IDX_W-1:0] upd_idx;
      logic                 unused_bp_bits;

      assign look_idx       = pc_q[BHT_IDX_W:1];
      assign upd_idx        = bus.bp_pc[BHT_IDX_W:1];
      // Lookup reads the registered table, so a same-cycle update is not seen.
      assign bht_pred       = bht_q[look_idx][1];
      assign unused_bp_bits = ^{bus.bp_pc[31:BHT_IDX_W+1], bus.bp_pc[0]};

      always_comb begin
        bht_d = bht_q;
        if (rdy_in && bus.bp_update) begin
          if (bus.bp_taken && bht_q[upd_idx] != 2'b11)
            bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
          else if (!bus.bp_taken && bht_q[upd_idx] != 2'b00)
            bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
        end
      end

      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b10;
        end else begin
          bht_q <= bht_d;
        end
      end
    end else begin : g_static
      logic unused_bp;

      assign bht_pred  = (PRED_MODE == 1);
      assign unused_bp = ^{bus.bp_update, bus.bp_taken, bus.bp_pc};
    end
  endgenerate

  // ---------------------------------------------------------------- control
  always_comb begin
    pc_d     = pc_q;
    frozen_d = frozen_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    if (rdy_in) begin
      if (clear) begin
        head_d   = '0;
        tail_d   = '0;
        count_d  = '0;
        pc_d     = corr_jump_addr;
        frozen_d = 1'b0;
      end else begin
        if (push) begin
          tail_d = tail_q + 1'b1;
          // jalr target is unknown here: park the PC until the ROB melts us.
          if (is_jalr) frozen_d = 1'b1;
          else         pc_d     = next_pc;
        end
        if (pop) head_d = head_q + 1'b1;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        if (melt) begin
          frozen_d = 1'b0;
          pc_d     = corr_jump_addr;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc_q     <= RESET_PC;
      frozen_q <= 1'b0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      frozen_q <= frozen_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: nothing is visible unless count_q covers it.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_inst_q[tail_q]    <= bus.inst_val;
      mem_pc_q[tail_q]      <= pc_q;
      mem_is_c_q[tail_q]    <= bus.is_c;
      mem_pred_q[tail_q]    <= pred_taken;
      mem_next_pc_q[tail_q] <= next_pc;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus.if_enable      = !rst_in && !frozen_q && !clear && !full;
  assign bus.if_addr        = pc_q;
  assign bus.out_valid      = head_valid;
  assign bus.out_inst       = head_valid ? mem_inst_q[head_q]    : 32'h0;
  assign bus.out_pc         = head_valid ? mem_pc_q[head_q]      : 32'h0;
  assign bus.out_is_c       = head_valid ? mem_is_c_q[head_q]    : 1'b0;
  assign bus.out_pred_taken = head_valid ? mem_pred_q[head_q]    : 1'b0;
  assign bus.out_next_pc    = head_valid ? mem_next_pc_q[head_q] : 32'h0;

  assign dbg_count  = count_q;
  assign dbg_frozen = frozen_q;

endmodule

// File: tb/tb_fetch_queue_bp.sv
// Directed bench for fetch_queue_bp: fill/drop, prediction training, jalr
// freeze/melt, clear and mid-stream reset, with hand-computed expectations.
module tb_fetch_queue_bp;
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        melt;
  logic [31:0] corr_jump_addr;
  logic [3:0]  dbg_count;
  logic        dbg_frozen;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] NOP  = 32'h0000_0013; // addi x0,x0,0
  localparam logic [31:0] BR   = 32'hFE00_08E3; // beq x0,x0,-16
  localparam logic [31:0] CADD = 32'h0020_80B3; // add x1,x1,x2 (from c.add)
  localparam logic [31:0] JALR = 32'h0000_8067; // jalr x0,0(x1)
  localparam logic [31:0] JAL  = 32'h0080_006F; // jal x0,+8

  fetch_queue_bp_if bus ();

  fetch_queue_bp #(
    .IQ_DEPTH(8), .BHT_ENTRIES(16), .PRED_MODE(2), .RESET_PC(32'h0)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .melt(melt), .corr_jump_addr(corr_jump_addr), .bus(bus),
    .dbg_count(dbg_count), .dbg_frozen(dbg_frozen)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic fetch(input logic [31:0] inst, input logic c);
    bus.inst_ready = 1'b1;
    bus.inst_val   = inst;
    bus.is_c       = c;
    step();
    bus.inst_ready = 1'b0;
    bus.is_c       = 1'b0;
  endtask

  task automatic do_clear(input logic [31:0] addr);
    clear          = 1'b1;
    corr_jump_addr = addr;
    step();
    clear = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input logic taken);
    bus.bp_update = 1'b1;
    bus.bp_pc     = pc;
    bus.bp_taken  = taken;
    step();
    bus.bp_update = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; melt = 1'b0; corr_jump_addr = '0;
    bus.inst_ready = 1'b0; bus.is_c = 1'b0; bus.inst_val = '0; bus.out_ready = 1'b0;
    bus.bp_update = 1'b0; bus.bp_pc = '0; bus.bp_taken = 1'b0;

    // Reset state
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_if_enable", 32'(bus.if_enable), 32'h0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    step(); step();
    rst_in = 1'b0;
    #1;
    chk("post_rst_if_addr", bus.if_addr, 32'h0);
    chk("post_rst_if_enable", 32'(bus.if_enable), 32'h1);
    chk("post_rst_count", 32'(dbg_count), 32'h0);

    // Fill with eight 4-byte non-branches
    for (int i = 0; i < 8; i++) fetch(NOP, 1'b0);
    chk("fill_count", 32'(dbg_count), 32'h8);
    chk("fill_if_enable", 32'(bus.if_enable), 32'h0);
    chk("fill_if_addr", bus.if_addr, 32'h20);
    chk("fill_head_pc", bus.out_pc, 32'h0);
    chk("fill_head_next", bus.out_next_pc, 32'h4);
    chk("fill_head_inst", bus.out_inst, NOP);

    // rdy_in low freezes everything
    rdy_in = 1'b0; bus.out_ready = 1'b1;
    fetch(NOP, 1'b0);
    chk("hold_count", 32'(dbg_count), 32'h8);
    chk("hold_head_pc", bus.out_pc, 32'h0);
    rdy_in = 1'b1; bus.out_ready = 1'b0;

    // Ninth fetch on a full queue is dropped
    fetch(NOP, 1'b0);
    chk("drop_count", 32'(dbg_count), 32'h8);
    chk("drop_if_addr", bus.if_addr, 32'h20);

    // Push and pop together on full
    bus.out_ready = 1'b1;
    fetch(NOP, 1'b0);
    bus.out_ready = 1'b0;
    chk("pushpop_count", 32'(dbg_count), 32'h8);
    chk("pushpop_if_addr", bus.if_addr, 32'h24);
    chk("pushpop_head_pc", bus.out_pc, 32'h4);

    // Clear empties the queue and redirects
    clear = 1'b1; corr_jump_addr = 32'h40;
    #1;
    chk("clear_if_enable", 32'(bus.if_enable), 32'h0);
    step();
    clear = 1'b0;
    chk("clear_out_valid", 32'(bus.out_valid), 32'h0);
    chk("clear_out_inst", bus.out_inst, 32'h0);
    chk("clear_if_addr", bus.if_addr, 32'h40);

    // Branch with fresh (weakly taken) counter
    fetch(BR, 1'b0);
    chk("br0_pred", 32'(bus.out_pred_taken), 32'h1);
    chk("br0_next", bus.out_next_pc, 32'h30);
    chk("br0_if_addr", bus.if_addr, 32'h30);
    chk("br0_pc", bus.out_pc, 32'h40);

    // Three not-taken updates: 2 -> 1 -> 0 -> 0 (saturate)
    train(32'h40, 1'b0); train(32'h40, 1'b0); train(32'h40, 1'b0);
    do_clear(32'h40);
    fetch(BR, 1'b0);
    chk("br1_pred", 32'(bus.out_pred_taken), 32'h0);
    chk("br1_next", bus.out_next_pc, 32'h44);
    chk("br1_if_addr", bus.if_addr, 32'h44);

    // Counter -> 1, then lookup coincident with an increment sees the old value
    train(32'h40, 1'b1);
    do_clear(32'h40);
    bus.bp_update = 1'b1; bus.bp_pc = 32'h40; bus.bp_taken = 1'b1;
    fetch(BR, 1'b0);
    bus.bp_update = 1'b0;
    chk("br2_nobypass_pred", 32'(bus.out_pred_taken), 32'h0);
    chk("br2_nobypass_next", bus.out_next_pc, 32'h44);
    do_clear(32'h40);
    fetch(BR, 1'b0);
    chk("br3_pred", 32'(bus.out_pred_taken), 32'h1);
    chk("br3_next", bus.out_next_pc, 32'h30);

    // Compressed instruction
    do_clear(32'h100);
    fetch(CADD, 1'b1);
    chk("c_is_c", 32'(bus.out_is_c), 32'h1);
    chk("c_next", bus.out_next_pc, 32'h102);
    chk("c_if_addr", bus.if_addr, 32'h102);
    chk("c_pc", bus.out_pc, 32'h100);

    // jalr freezes fetch
    do_clear(32'h200);
    fetch(JALR, 1'b0);
    chk("jalr_frozen", 32'(dbg_frozen), 32'h1);
    chk("jalr_next", bus.out_next_pc, 32'h204);
    chk("jalr_pred", 32'(bus.out_pred_taken), 32'h0);
    bus.inst_ready = 1'b1; bus.inst_val = NOP;
    for (int i = 0; i < 5; i++) begin
      chk("frz_if_enable", 32'(bus.if_enable), 32'h0);
      chk("frz_if_addr", bus.if_addr, 32'h200);
      step();
    end
    bus.inst_ready = 1'b0;
    chk("frz_count", 32'(dbg_count), 32'h1);

    // Melt redirects and unfreezes
    melt = 1'b1; corr_jump_addr = 32'h800;
    step();
    melt = 1'b0;
    chk("melt_if_addr", bus.if_addr, 32'h800);
    chk("melt_if_enable", 32'(bus.if_enable), 32'h1);
    chk("melt_frozen", 32'(dbg_frozen), 32'h0);

    // Five entries, then clear with fetch and drain both requested
    for (int i = 0; i < 4; i++) fetch(NOP, 1'b0);
    chk("five_count", 32'(dbg_count), 32'h5);
    chk("five_if_addr", bus.if_addr, 32'h810);
    bus.inst_ready = 1'b1; bus.inst_val = NOP; bus.out_ready = 1'b1;
    do_clear(32'h1000);
    bus.inst_ready = 1'b0; bus.out_ready = 1'b0;
    chk("clr5_out_valid", 32'(bus.out_valid), 32'h0);
    chk("clr5_count", 32'(dbg_count), 32'h0);
    chk("clr5_if_addr", bus.if_addr, 32'h1000);

    // jal, then a pop exposing the next entry
    fetch(JAL, 1'b0);
    chk("jal_pred", 32'(bus.out_pred_taken), 32'h1);
    chk("jal_next", bus.out_next_pc, 32'h1008);
    chk("jal_if_addr", bus.if_addr, 32'h1008);
    fetch(NOP, 1'b0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("pop_head_pc", bus.out_pc, 32'h1008);
    chk("pop_count", 32'(dbg_count), 32'h1);

    // Mid-stream reset: three entries, frozen, BHT index 2 trained to 0
    fetch(NOP, 1'b0);
    fetch(JALR, 1'b0);
    chk("pre_rst_count", 32'(dbg_count), 32'h3);
    chk("pre_rst_frozen", 32'(dbg_frozen), 32'h1);
    train(32'h44, 1'b0); train(32'h44, 1'b0);
    #2;
    rst_in = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_rst_if_enable", 32'(bus.if_enable), 32'h0);
    step();
    rst_in = 1'b0;
    #1;
    chk("rel_if_addr", bus.if_addr, 32'h0);
    chk("rel_frozen", 32'(dbg_frozen), 32'h0);
    chk("rel_count", 32'(dbg_count), 32'h0);
    do_clear(32'h44);
    fetch(BR, 1'b0);
    chk("rel_bht_pred", 32'(bus.out_pred_taken), 32'h1);
    chk("rel_bht_next", bus.out_next_pc, 32'h34);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
